// File: rtl/ysyx_25060170_pipe_ctrl.sv
// Pipeline hazard controller: load-use bubbles, redirect flushes, LSU wait stalls.
// Define YSYX_25060170_LSU_TIMEOUT_EN to build the LSU wait timeout and ERR state.
module ysyx_25060170_pipe_ctrl #(
    parameter int unsigned LSU_TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic        id_rs1_ren,
    input  logic        id_rs2_ren,
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_rd_ena,
    input  logic        ex_load_flag,
    input  logic        ex_redirect,
    input  logic        ls_req_valid,
    input  logic        ls_resp_valid,
    output logic        pc_hold,
    output logic        ifid_hold,
    output logic        ifid_flush,
    output logic        ctl_id_hold,
    output logic        ctl_ex_hold,
    output logic        ctl_id_flush,
    output logic        ctl_ie_flush,
    output logic        ctl_ls_flush,
    output logic        lsu_err,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_REDIR = 2'd2;
`ifdef YSYX_25060170_LSU_TIMEOUT_EN
    localparam logic [1:0] S_ERR   = 2'd3;
    localparam logic [15:0] WAIT_LAST = 16'(LSU_TIMEOUT - 1);
`endif

    logic [1:0]  state_q, state_d;
    logic        pending_q, pending_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic        load_use;

    assign load_use = ex_load_flag & ex_rd_ena & (ex_rd_addr != 5'd0) &
                      ((id_rs1_ren & (id_rs1_addr == ex_rd_addr)) |
                       (id_rs2_ren & (id_rs2_addr == ex_rd_addr)));

`ifdef YSYX_25060170_LSU_TIMEOUT_EN
    logic [15:0] wait_cnt_q, wait_cnt_d;

    assign wait_cnt_d = (state_q == S_WAIT) ? wait_cnt_q + 16'd1 : '0;

    always_ff @(posedge clk) begin
        if (rst) wait_cnt_q <= '0;
        else     wait_cnt_q <= wait_cnt_d;
    end
`else
    // Parameter kept so instantiations stay identical whether or not the timeout is built.
    logic [15:0] unused_timeout;
    assign unused_timeout = 16'(LSU_TIMEOUT);
`endif

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        pc_hold      = 1'b0;
        ifid_hold    = 1'b0;
        ifid_flush   = 1'b0;
        ctl_id_hold  = 1'b0;
        ctl_ex_hold  = 1'b0;
        ctl_ie_flush = 1'b0;
        ctl_ls_flush = 1'b0;
        lsu_err      = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A redirect makes the ID instruction wrong-path, so its hazard is moot.
                if (ex_redirect) begin
                    ifid_flush   = 1'b1;
                    ctl_ie_flush = 1'b1;
                end else if (load_use) begin
                    pc_hold      = 1'b1;
                    ifid_hold    = 1'b1;
                    ctl_ie_flush = 1'b1;
                end
                if (ls_req_valid && !ls_resp_valid) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ls_resp_valid) begin
                    state_d = (pending_q || ex_redirect) ? S_REDIR : S_IDLE;
                end else begin
                    pc_hold     = 1'b1;
                    ifid_hold   = 1'b1;
                    ctl_id_hold = 1'b1;
                    ctl_ex_hold = 1'b1;
                    if (ex_redirect) pending_d = 1'b1;
`ifdef YSYX_25060170_LSU_TIMEOUT_EN
                    if (wait_cnt_q == WAIT_LAST) state_d = S_ERR;
`endif
                end
            end
            S_REDIR: begin
                ifid_flush   = 1'b1;
                ctl_ie_flush = 1'b1;
                pending_d    = 1'b0;
                state_d      = S_IDLE;
            end
`ifdef YSYX_25060170_LSU_TIMEOUT_EN
            S_ERR: begin
                pc_hold      = 1'b1;
                ifid_hold    = 1'b1;
                ctl_id_hold  = 1'b1;
                ctl_ex_hold  = 1'b1;
                ctl_ls_flush = 1'b1;
                lsu_err      = 1'b1;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign ctl_id_flush = 1'b0;

    assign stall_cnt_d = stall_cnt_q + {31'd0, pc_hold};
    assign flush_cnt_d = flush_cnt_q + {31'd0, ctl_ie_flush};
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pending_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule
